// File: rtl/proc_ctrl.sv
// proc_ctrl: TinyRV1 five-stage pipeline controller (F, D, X, M, W).
// Define PROC_CTRL_BYPASS_EN for full bypassing; otherwise RAW hazards stall.
module proc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d2c_inst,
  input  logic        d2c_eq_X,
  output logic        c2d_imemreq_val,
  output logic        c2d_reg_en_F,
  output logic [1:0]  c2d_pc_sel_F,
  output logic        c2d_reg_en_D,
  output logic [1:0]  c2d_op1_byp_sel_D,
  output logic [1:0]  c2d_op2_byp_sel_D,
  output logic [1:0]  c2d_sd_byp_sel_D,
  output logic        c2d_op1_sel_D,
  output logic        c2d_op2_sel_D,
  output logic        c2d_alu_fn_X,
  output logic        c2d_result_sel_X,
  output logic        c2d_dmemreq_val_M,
  output logic        c2d_dmemreq_type_M,
  output logic        c2d_wb_sel_M,
  output logic        c2d_rf_wen_W,
  output logic [4:0]  c2d_rf_waddr_W
);
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JR   = 7'b1100111;
  localparam logic [6:0] OP_BNE  = 7'b1100011;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = d2c_inst[6:0];
  assign rd  = d2c_inst[11:7];
  assign f3  = d2c_inst[14:12];
  assign rs1 = d2c_inst[19:15];
  assign rs2 = d2c_inst[24:20];
  assign f7  = d2c_inst[31:25];

  logic       val_D_q, val_D_d;
  logic       val_X_q, lw_X_q, sw_X_q, bne_X_q, jal_X_q, wen_X_q;
  logic [4:0] rd_X_q;
  logic       val_M_q, lw_M_q, sw_M_q, wen_M_q;
  logic [4:0] rd_M_q;
  logic       val_W_q, wen_W_q;
  logic [4:0] rd_W_q;
  logic       val_X_d;

  logic add_D, addi_D, lw_D, sw_D, jal_D, jr_D, bne_D;
  always_comb begin
    add_D  = 1'b0;
    addi_D = 1'b0;
    lw_D   = 1'b0;
    sw_D   = 1'b0;
    jal_D  = 1'b0;
    jr_D   = 1'b0;
    bne_D  = 1'b0;
    if (val_D_q) begin
      unique case (opc)
        OP_ADD:  add_D  = (f3 == 3'b000) && (f7 == 7'd0);
        OP_ADDI: addi_D = (f3 == 3'b000);
        OP_LW:   lw_D   = (f3 == 3'b010);
        OP_SW:   sw_D   = (f3 == 3'b010);
        OP_JAL:  jal_D  = 1'b1;
        OP_JR:   jr_D   = (f3 == 3'b000);
        OP_BNE:  bne_D  = (f3 == 3'b001);
        default: ;
      endcase
    end
  end

  logic rs1_use, rs2_use, wen_D;
  assign rs1_use = add_D | addi_D | lw_D | sw_D | jr_D | bne_D;
  assign rs2_use = add_D | sw_D | bne_D;
  assign wen_D   = (add_D | addi_D | lw_D | jal_D) && (rd != 5'd0);

  // wen_* already excludes rd = x0, so a hit implies a nonzero source
  logic r1_x, r1_m, r1_w, r2_x, r2_m, r2_w;
  assign r1_x = rs1_use && val_X_q && wen_X_q && (rd_X_q == rs1);
  assign r1_m = rs1_use && val_M_q && wen_M_q && (rd_M_q == rs1);
  assign r1_w = rs1_use && val_W_q && wen_W_q && (rd_W_q == rs1);
  assign r2_x = rs2_use && val_X_q && wen_X_q && (rd_X_q == rs2);
  assign r2_m = rs2_use && val_M_q && wen_M_q && (rd_M_q == rs2);
  assign r2_w = rs2_use && val_W_q && wen_W_q && (rd_W_q == rs2);

  function automatic logic [1:0] byp(input logic x, m, w);
    if (x)      return 2'd1;
    else if (m) return 2'd2;
    else if (w) return 2'd3;
    return 2'd0;
  endfunction

  logic       stall_D;
  logic [1:0] byp1, byp2;
`ifdef PROC_CTRL_BYPASS_EN
  assign stall_D = lw_X_q && (r1_x || r2_x);
  assign byp1    = byp(r1_x, r1_m, r1_w);
  assign byp2    = byp(r2_x, r2_m, r2_w);
`else
  assign stall_D = r1_x | r1_m | r1_w | r2_x | r2_m | r2_w;
  assign byp1    = 2'd0;
  assign byp2    = 2'd0;
`endif

  logic taken_X, jump_D;
  assign taken_X = val_X_q && bne_X_q && !d2c_eq_X;
  assign jump_D  = (jal_D | jr_D) && !stall_D;

  always_comb begin
    c2d_pc_sel_F = 2'd0;
    if (taken_X)      c2d_pc_sel_F = 2'd3;
    else if (stall_D) c2d_pc_sel_F = 2'd0;
    else if (jal_D)   c2d_pc_sel_F = 2'd1;
    else if (jr_D)    c2d_pc_sel_F = 2'd2;
  end

  always_comb begin
    val_D_d = 1'b1;
    if (taken_X)      val_D_d = 1'b0;
    else if (stall_D) val_D_d = val_D_q;
    else if (jump_D)  val_D_d = 1'b0;
    val_X_d = val_D_q && !stall_D && !taken_X;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_D_q <= 1'b0;
      val_X_q <= 1'b0;
      lw_X_q  <= 1'b0;
      sw_X_q  <= 1'b0;
      bne_X_q <= 1'b0;
      jal_X_q <= 1'b0;
      wen_X_q <= 1'b0;
      rd_X_q  <= 5'd0;
      val_M_q <= 1'b0;
      lw_M_q  <= 1'b0;
      sw_M_q  <= 1'b0;
      wen_M_q <= 1'b0;
      rd_M_q  <= 5'd0;
      val_W_q <= 1'b0;
      wen_W_q <= 1'b0;
      rd_W_q  <= 5'd0;
    end else begin
      val_D_q <= val_D_d;
      val_X_q <= val_X_d;
      lw_X_q  <= lw_D;
      sw_X_q  <= sw_D;
      bne_X_q <= bne_D;
      jal_X_q <= jal_D;
      wen_X_q <= wen_D;
      rd_X_q  <= rd;
      val_M_q <= val_X_q;
      lw_M_q  <= lw_X_q;
      sw_M_q  <= sw_X_q;
      wen_M_q <= wen_X_q;
      rd_M_q  <= rd_X_q;
      val_W_q <= val_M_q;
      wen_W_q <= wen_M_q;
      rd_W_q  <= rd_M_q;
    end
  end

  assign c2d_imemreq_val    = rst;
  assign c2d_reg_en_F       = !stall_D | taken_X;
  assign c2d_reg_en_D       = !stall_D | taken_X;
  assign c2d_op1_byp_sel_D  = byp1;
  assign c2d_op2_byp_sel_D  = byp2;
  assign c2d_sd_byp_sel_D   = sw_D ? byp2 : 2'd0;
  assign c2d_op1_sel_D      = jal_D;
  assign c2d_op2_sel_D      = addi_D | lw_D | sw_D;
  assign c2d_alu_fn_X       = val_X_q & bne_X_q;
  assign c2d_result_sel_X   = val_X_q & jal_X_q;
  assign c2d_dmemreq_val_M  = val_M_q & (lw_M_q | sw_M_q);
  assign c2d_dmemreq_type_M = val_M_q & sw_M_q;
  assign c2d_wb_sel_M       = val_M_q & lw_M_q;
  assign c2d_rf_wen_W       = val_W_q & wen_W_q;
  assign c2d_rf_waddr_W     = rd_W_q;
endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Pipeline controller for the five-stage TinyRV1 processor datapath (F, D, X, M, W).
- Decodes the instruction held in the D-stage register and tracks valid, type and destination for each stage.
- Drives every datapath control signal: stall, squash, PC select, bypass select, operand select, ALU function and writeback.
- Instantiated beside the datapath inside the processor top.

Parameters:
- None. The ISA subset (ADD, ADDI, LW, SW, JAL, JR, BNE) is fixed.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
d2c_inst  in  32  instruction in D-stage register
d2c_eq_X  in  1  ALU compare result in X (1 = operands equal)
c2d_imemreq_val  out  1  instruction fetch request valid
c2d_reg_en_F  out  1  PC register enable
c2d_pc_sel_F  out  2  0 pc+4, 1 JAL target, 2 JR target, 3 BNE target
c2d_reg_en_D  out  1  F/D instruction register enable
c2d_op1_byp_sel_D  out  2  0 regfile, 1 X, 2 M, 3 W
c2d_op2_byp_sel_D  out  2  same encoding as op1
c2d_sd_byp_sel_D  out  2  SW store-data source, same encoding
c2d_op1_sel_D  out  1  0 bypassed rs1, 1 pc_D (JAL)
c2d_op2_sel_D  out  1  0 bypassed rs2, 1 immediate
c2d_alu_fn_X  out  1  0 add, 1 equality compare
c2d_result_sel_X  out  1  0 ALU, 1 pc+4 (JAL link)
c2d_dmemreq_val_M  out  1  data memory request valid
c2d_dmemreq_type_M  out  1  0 read, 1 write
c2d_wb_sel_M  out  1  0 X result, 1 load data
c2d_rf_wen_W  out  1  regfile write enable
c2d_rf_waddr_W  out  5  regfile write address

Behaviour:
- Reset (rst=0, asynchronous):
  - val_D, val_X, val_M, val_W = 0; imemreq_val = 0.
  - All other outputs 0, except reg_en_F = reg_en_D = 1.
- First fetch is the cycle after rst rises. Valid bits clear asynchronously if reset is asserted mid-operation; in-flight instructions are lost.
- Decode (RISC-V fields):
  - ADD: 0110011, f3 000, f7 0
  - ADDI: 0010011, f3 000
  - LW: 0000011, f3 010
  - SW: 0100011, f3 010
  - JAL: 1101111
  - JR: 1100111, f3 000
  - BNE: 1100011, f3 001
  - Any other encoding decodes as a NOP: no writes, no hazards.
- Register writers: ADD, ADDI, LW, JAL. Writes with rd = x0 are suppressed (wen = 0).
- Sources: rs1 is read by ADD, ADDI, LW, SW, JR, BNE. rs2 is read by ADD, SW, BNE.
- Bypass, per source:
  - If the source is x0, select 0.
  - Otherwise select the youngest valid writer with matching rd, priority X(1) > M(2) > W(3). With no match, select 0.
  - ADDI, LW and SW drive op2_sel = 1; SW store data uses sd_byp_sel.
- stall_D: val_D and the D instruction reads a register that the LW in X writes (load-use).
- JAL and JR resolve in D when not stalled:
  - pc_sel = 1 or 2; the instruction fetched this cycle is squashed (val_D next = 0).
- BNE resolves in X:
  - taken = val_X & BNE & !eq_X.
  - When taken: pc_sel = 3; D and F are squashed (val_X next = 0, val_D next = 0).
- Priority: taken_X > stall_D > jump_D > pc+4.
- Enables: reg_en_F = reg_en_D = !stall_D | taken_X.
- Stall: val_X next = 0 (bubble inserted); D holds its instruction.
- Stage advance: X→M and M→W move every cycle.
- W outputs: rf_wen_W = val_W & wen_W; rf_waddr_W = rd_W.
- M outputs: dmemreq_val_M = val_M & (LW | SW); wb_sel_M = val_M & LW.
- Latency: 1 instruction per cycle with no hazards. Load-use costs 1 bubble; JAL/JR cost 1 cycle; taken BNE costs 2 cycles.

Optional Feature:
- Macro: PROC_CTRL_BYPASS_EN.
- Defined: full bypassing as above.
- Undefined:
  - All byp_sel outputs are forced to 0.
  - stall_D asserts whenever a valid writer in X, M or W matches a nonzero source of the D instruction.
  - Back-to-back dependent ADDs therefore cost 3 bubbles.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release → all val bits 0, rf_wen_W=0, imemreq_val=1 on the first cycle after release; assert rst mid-stream → rf_wen_W drops to 0 immediately.
- Dependent ADDs: addi x1,x0,5; add x2,x1,x1; add x3,x2,x1 → op1/op2_byp_sel = 1 for the second instruction, x3 = 15, zero stalls with bypass enabled; 3 bubbles each without it.
- Load-use: lw x4,0(x1); add x5,x4,x4 → exactly one cycle with reg_en_D=0 and an X bubble, then op1_byp_sel = op2_byp_sel = 2.
- JAL: jal x1,+8 → pc_sel=1 for one cycle, next fetched instruction has val_D=0, rf_wen_W with waddr=1 three cycles later.
- BNE: bne x1,x2 with x1=1, x2=2 → pc_sel=3, both younger instructions squashed (no rf_wen_W); with x1=x2=3 → not taken, no squash.
- x0 rules: addi x0,x0,7; add x6,x0,x0 → no write to x0, byp_sel=0, x6 = 0.
